// File: rtl/reg_file_pkg.sv
// Shared defaults and address helpers for the multi-port register file.
package reg_file_pkg;

    localparam int unsigned N_DEF        = 32;
    localparam int unsigned DEPTH_DEF    = 16;
    localparam int unsigned NUM_READ_DEF = 3;
    localparam int unsigned PC_INDEX_DEF = 15;

    // Register-address width for a given depth; at least one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    localparam int unsigned ADDR_W_DEF = addr_w(DEPTH_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-load scoreboard: reservation sets a bit, load writeback clears it.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned PC_INDEX = PC_INDEX_DEF,
    parameter int unsigned ADDR_W   = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rsv_en,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    input  logic              i_w1_en,
    input  logic [ADDR_W-1:0] i_w1_addr,
    output logic [DEPTH-1:0]  o_busy
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    // A new reservation beats a same-cycle clear; the PC entry is never reserved.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_rsv_en && (i_rsv_addr == ADDR_W'(i)) && (i != PC_INDEX)) begin
                w_busy_nxt[i] = 1'b1;
            end else if (i_w1_en && (i_w1_addr == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, write-to-read bypass,
// PC mirror entry and a pending-load scoreboard.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned N        = N_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned NUM_READ = NUM_READ_DEF,
    parameter int unsigned PC_INDEX = PC_INDEX_DEF,
    parameter int unsigned ADDR_W   = addr_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_READ*ADDR_W-1:0] raddr_i,
    output logic [NUM_READ*N-1:0]      rdata_o,
    output logic [NUM_READ-1:0]        rbusy_o,
    input  logic                       w0_en_i,
    input  logic [ADDR_W-1:0]          w0_addr_i,
    input  logic [N-1:0]               w0_data_i,
    input  logic                       w1_en_i,
    input  logic [ADDR_W-1:0]          w1_addr_i,
    input  logic [N-1:0]               w1_data_i,
    input  logic                       rsv_en_i,
    input  logic [ADDR_W-1:0]          rsv_addr_i,
    input  logic [N-1:0]               r15_i,
    output logic [DEPTH-1:0]           busy_o,
    output logic                       pc_err_o
);

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_INDEX);

    logic [N-1:0]     r_mem [DEPTH];
    logic             r_pc_err;
    logic [DEPTH-1:0] w_busy;
    logic             w_w0_pc;
    logic             w_w1_pc;
    logic             w_rsv_pc;

    assign w_w0_pc  = w0_en_i  && (w0_addr_i  == PC_ADDR);
    assign w_w1_pc  = w1_en_i  && (w1_addr_i  == PC_ADDR);
    assign w_rsv_pc = rsv_en_i && (rsv_addr_i == PC_ADDR);

    // w0 is applied last so it wins a same-address collision with w1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pc_err <= 1'b0;
        end else begin
            if (w1_en_i && !w_w1_pc) begin
                r_mem[w1_addr_i] <= w1_data_i;
            end
            if (w0_en_i && !w_w0_pc) begin
                r_mem[w0_addr_i] <= w0_data_i;
            end
            r_pc_err <= w_w0_pc || w_w1_pc || w_rsv_pc;
        end
    end

    reg_file_scoreboard #(
        .DEPTH    (DEPTH),
        .PC_INDEX (PC_INDEX),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_rsv_en   (rsv_en_i),
        .i_rsv_addr (rsv_addr_i),
        .i_w1_en    (w1_en_i),
        .i_w1_addr  (w1_addr_i),
        .o_busy     (w_busy)
    );

    // Per-port read mux: PC mirror, then w0 bypass, then w1 bypass, then storage.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [N-1:0]      w_data;
        logic              w_w1_hit;

        assign w_addr   = raddr_i[k*ADDR_W +: ADDR_W];
        assign w_w1_hit = w1_en_i && (w1_addr_i == w_addr);

        always_comb begin
            w_data = r_mem[w_addr];
            if (w_addr == PC_ADDR) begin
                w_data = r15_i;
            end else if (w0_en_i && (w0_addr_i == w_addr)) begin
                w_data = w0_data_i;
            end else if (w_w1_hit) begin
                w_data = w1_data_i;
            end
        end

        assign rdata_o[k*N +: N] = w_data;
        assign rbusy_o[k]        = w_busy[w_addr] && !w_w1_hit && (w_addr != PC_ADDR);
    end

    assign busy_o   = w_busy;
    assign pc_err_o = r_pc_err;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    localparam int unsigned N  = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned NR = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*AW-1:0] raddr_i;
    logic [NR*N-1:0]  rdata_o;
    logic [NR-1:0]    rbusy_o;
    logic             w0_en_i, w1_en_i, rsv_en_i;
    logic [AW-1:0]    w0_addr_i, w1_addr_i, rsv_addr_i;
    logic [N-1:0]     w0_data_i, w1_data_i, r15_i;
    logic [15:0]      busy_o;
    logic             pc_err_o;

    int total = 0;
    int bad   = 0;

    reg_file_mp dut (
        .clk        (clk),
        .rst        (rst),
        .raddr_i    (raddr_i),
        .rdata_o    (rdata_o),
        .rbusy_o    (rbusy_o),
        .w0_en_i    (w0_en_i),
        .w0_addr_i  (w0_addr_i),
        .w0_data_i  (w0_data_i),
        .w1_en_i    (w1_en_i),
        .w1_addr_i  (w1_addr_i),
        .w1_data_i  (w1_data_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .r15_i      (r15_i),
        .busy_o     (busy_o),
        .pc_err_o   (pc_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_ra(input int k, input reg_addr_t a);
        raddr_i[k*AW +: AW] = a;
    endtask

    function automatic logic [31:0] rd(input int k);
        return rdata_o[k*N +: N];
    endfunction

    task automatic idle();
        w0_en_i  = 1'b0;
        w1_en_i  = 1'b0;
        rsv_en_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; raddr_i = '0; idle();
        w0_addr_i = '0; w1_addr_i = '0; rsv_addr_i = '0;
        w0_data_i = '0; w1_data_i = '0; r15_i = '0;
        tick(); tick();
        rst = 1'b0;

        // Junk before reset
        w0_en_i = 1'b1; w0_addr_i = 4'd1; w0_data_i = 32'hAAAA_AAAA;
        w1_en_i = 1'b1; w1_addr_i = 4'd2; w1_data_i = 32'hBBBB_BBBB;
        rsv_en_i = 1'b1; rsv_addr_i = 4'd6;
        tick(); idle();
        set_ra(0, 4'd1); settle();
        chk("junk_r1", rd(0), 32'hAAAA_AAAA);
        chk("junk_busy", 32'(busy_o), 32'h0000_0040);

        // Reset cycle with a write that must be ignored; PC still mirrored
        rst = 1'b1; r15_i = 32'h0000_1234;
        w0_en_i = 1'b1; w0_addr_i = 4'd3; w0_data_i = 32'h1111_1111;
        set_ra(1, 4'd15); settle();
        chk("rst_pc_read", rd(1), 32'h0000_1234);
        tick(); idle(); rst = 1'b0;
        for (int r = 0; r < 15; r++) begin
            set_ra(0, reg_addr_t'(r)); settle();
            chk($sformatf("rst_r%0d", r), rd(0), 32'h0);
        end
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_pcerr", 32'(pc_err_o), 32'h0);

        // Same-cycle bypass
        w0_en_i = 1'b1; w0_addr_i = 4'd3; w0_data_i = 32'hDEAD_BEEF;
        set_ra(0, 4'd3); settle();
        chk("byp_same", rd(0), 32'hDEAD_BEEF);
        tick(); idle(); settle();
        chk("byp_after", rd(0), 32'hDEAD_BEEF);

        // Write collision: w0 wins
        w0_en_i = 1'b1; w0_addr_i = 4'd4; w0_data_i = 32'h1;
        w1_en_i = 1'b1; w1_addr_i = 4'd4; w1_data_i = 32'h2;
        set_ra(1, 4'd4); settle();
        chk("coll_byp", rd(1), 32'h1);
        tick(); idle(); settle();
        chk("coll_store", rd(1), 32'h1);

        // PC mirror and error pulse
        r15_i = 32'h0000_1008;
        w0_en_i = 1'b1; w0_addr_i = 4'd15; w0_data_i = 32'hFFFF_FFFF;
        set_ra(2, 4'd15); settle();
        chk("pc_read_wr", rd(2), 32'h0000_1008);
        chk("pc_err_pre", 32'(pc_err_o), 32'h0);
        chk("pc_rbusy", 32'(rbusy_o[2]), 32'h0);
        tick(); idle(); settle();
        chk("pc_err_hi", 32'(pc_err_o), 32'h1);
        chk("pc_read", rd(2), 32'h0000_1008);
        chk("pc_busy", 32'(busy_o), 32'h0);
        tick(); settle();
        chk("pc_err_lo", 32'(pc_err_o), 32'h0);

        // Scoreboard set and load writeback
        rsv_en_i = 1'b1; rsv_addr_i = 4'd7;
        set_ra(0, 4'd7); settle();
        chk("sb_pre", 32'(busy_o), 32'h0);
        tick(); idle(); settle();
        chk("sb_set", 32'(busy_o), 32'h0000_0080);
        chk("sb_rbusy", 32'(rbusy_o[0]), 32'h1);
        w1_en_i = 1'b1; w1_addr_i = 4'd7; w1_data_i = 32'h55; settle();
        chk("sb_w1_rbusy", 32'(rbusy_o[0]), 32'h0);
        chk("sb_w1_data", rd(0), 32'h55);
        chk("sb_w1_raw", 32'(busy_o), 32'h0000_0080);
        tick(); idle(); settle();
        chk("sb_clr", 32'(busy_o), 32'h0);
        chk("sb_data", rd(0), 32'h55);

        // Set wins over same-cycle clear
        rsv_en_i = 1'b1; rsv_addr_i = 4'd2;
        tick(); idle(); settle();
        chk("sw_busy", 32'(busy_o), 32'h0000_0004);
        rsv_en_i = 1'b1; rsv_addr_i = 4'd2;
        w1_en_i = 1'b1; w1_addr_i = 4'd2; w1_data_i = 32'h9;
        tick(); idle(); set_ra(0, 4'd2); settle();
        chk("sw_data", rd(0), 32'h9);
        chk("sw_keep", 32'(busy_o), 32'h0000_0004);
        chk("sw_rbusy", 32'(rbusy_o[0]), 32'h1);

        // Reservation aimed at PC is dropped and flagged
        rsv_en_i = 1'b1; rsv_addr_i = 4'd15;
        tick(); idle(); settle();
        chk("rsvpc_busy", 32'(busy_o), 32'h0000_0004);
        chk("rsvpc_err", 32'(pc_err_o), 32'h1);

        // Reset mid-load discards reservations
        rsv_en_i = 1'b1; rsv_addr_i = 4'd5;
        tick(); idle(); settle();
        chk("ml_busy", 32'(busy_o), 32'h0000_0024);
        rst = 1'b1;
        tick(); rst = 1'b0; settle();
        chk("ml_rst_busy", 32'(busy_o), 32'h0);
        w1_en_i = 1'b1; w1_addr_i = 4'd5; w1_data_i = 32'h77;
        tick(); idle(); set_ra(1, 4'd5); settle();
        chk("ml_data", rd(1), 32'h77);
        chk("ml_err", 32'(pc_err_o), 32'h0);
        chk("ml_busy_after", 32'(busy_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
